// File: rtl/vend_pkg.sv
// vend_pkg: shared types and helpers for the vending-machine sequencer.
//   vend_state_t : sequencer state encoding
//   COIN_*       : coin-acceptor codes
//   coin_value() : coin code -> credit in units
//   ITEM_W       : width of the item index
package vend_pkg;

    localparam int ITEM_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_VEND    = 3'd2,
        ST_CHANGE  = 3'd3,
        ST_REFUND  = 3'd4
    } vend_state_t;

    localparam logic [1:0] COIN_1  = 2'b00;
    localparam logic [1:0] COIN_2  = 2'b01;
    localparam logic [1:0] COIN_5  = 2'b10;
    localparam logic [1:0] COIN_10 = 2'b11;

    function automatic logic [3:0] coin_value(input logic [1:0] code);
        logic [3:0] v;
        case (code)
            COIN_1:  v = 4'd1;
            COIN_2:  v = 4'd2;
            COIN_5:  v = 4'd5;
            COIN_10: v = 4'd10;
            default: v = 4'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_idle_timer.sv
// vend_idle_timer: counts idle cycles while enabled.
//   clk, reset : clock, async active-high reset
//   clear      : restart the count from zero
//   enable     : count only while high; count is held at zero otherwise
//   expired    : high while enabled and the count has reached TIMEOUT_CYC-1
// The owner leaves the counting state on expiry, so expired lasts one cycle.
module vend_idle_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] count_r;

    // Idle counter: zero outside the counting state or on clear, saturates at LAST.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (clear || !enable) begin
            count_r <= '0;
        end else if (count_r != LAST) begin
            count_r <= count_r + 1'b1;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = enable && (count_r == LAST);

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending-machine sequencer.
//   coin_valid/coin_code  : coin strobe and denomination
//   sel_valid/item_sel    : item-select strobe and index
//   cancel                : cancel strobe (refund in COLLECT)
//   balance               : live value of the external balance register
//   change_ack            : dispenser took change_amount
//   add_en/add_value      : credit the balance register (same cycle as coin)
//   clear_en              : clear the balance register
//   vend_pulse/item_id    : dispense command
//   change_valid/amount   : change or refund, held until change_ack
//   coin_reject           : coin returned without credit
//   insuff_funds          : selection refused
//   busy                  : in VEND, CHANGE or REFUND
module vend_ctrl
    import vend_pkg::*;
#(
    parameter logic [3:0] PRICE0      = 4'd3,
    parameter logic [3:0] PRICE1      = 4'd5,
    parameter logic [3:0] PRICE2      = 4'd7,
    parameter logic [3:0] PRICE3      = 4'd10,
    parameter int         TIMEOUT_CYC = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              coin_valid,
    input  logic [1:0]        coin_code,
    input  logic              sel_valid,
    input  logic [ITEM_W-1:0] item_sel,
    input  logic              cancel,
    input  logic [3:0]        balance,
    input  logic              change_ack,
    output logic              add_en,
    output logic [3:0]        add_value,
    output logic              clear_en,
    output logic              vend_pulse,
    output logic [ITEM_W-1:0] item_id,
    output logic              change_valid,
    output logic [3:0]        change_amount,
    output logic              coin_reject,
    output logic              insuff_funds,
    output logic              busy
);

    vend_state_t       state_r, state_nxt_s;
    logic [ITEM_W-1:0] item_id_r;
    logic [3:0]        change_amount_r;
    logic              vend_pulse_r, change_valid_r, busy_r;

    logic [3:0]        coin_val_s, price_s, load_amount_s;
    logic [4:0]        sum_s;
    logic              add_en_s, coin_reject_s, insuff_s, clear_s;
    logic              load_amount_en_s, load_item_en_s;
    logic              timer_clear_s, timer_en_s, timer_expired_s;

    assign coin_val_s = coin_value(coin_code);
    assign sum_s      = {1'b0, balance} + {1'b0, coin_val_s};
    assign timer_en_s = (state_r == ST_COLLECT);

    // Price lookup for the selected item.
    always_comb begin
        case (item_sel)
            2'd0:    price_s = PRICE0;
            2'd1:    price_s = PRICE1;
            2'd2:    price_s = PRICE2;
            2'd3:    price_s = PRICE3;
            default: price_s = PRICE0;
        endcase
    end

    vend_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_idle_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear_s),
        .enable  (timer_en_s),
        .expired (timer_expired_s)
    );

    // Next-state and event handling; one event per cycle, cancel > select > coin > timeout.
    always_comb begin
        state_nxt_s      = state_r;
        add_en_s         = 1'b0;
        coin_reject_s    = 1'b0;
        insuff_s         = 1'b0;
        clear_s          = 1'b0;
        load_amount_en_s = 1'b0;
        load_item_en_s   = 1'b0;
        load_amount_s    = balance;
        timer_clear_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_COLLECT: begin
                if (cancel && (state_r == ST_COLLECT)) begin
                    state_nxt_s      = ST_REFUND;
                    load_amount_en_s = 1'b1;
                    coin_reject_s    = coin_valid;
                end else if (sel_valid) begin
                    timer_clear_s = 1'b1;
                    coin_reject_s = coin_valid;
                    if (balance >= price_s) begin
                        state_nxt_s      = ST_VEND;
                        load_amount_en_s = 1'b1;
                        load_item_en_s   = 1'b1;
                        load_amount_s    = balance - price_s;
                    end else begin
                        insuff_s = 1'b1;
                    end
                end else if (coin_valid && !sum_s[4]) begin
                    add_en_s      = 1'b1;
                    timer_clear_s = 1'b1;
                    state_nxt_s   = ST_COLLECT;
                end else if (timer_expired_s) begin
                    // An overflowing coin is not an event, so the timeout still fires.
                    state_nxt_s      = ST_REFUND;
                    load_amount_en_s = 1'b1;
                    coin_reject_s    = coin_valid;
                end else begin
                    coin_reject_s = coin_valid;
                end
            end
            ST_VEND: begin
                coin_reject_s = coin_valid;
                if (change_amount_r == 4'd0) begin
                    clear_s     = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CHANGE;
                end
            end
            ST_CHANGE, ST_REFUND: begin
                coin_reject_s = coin_valid;
                if (change_ack) begin
                    clear_s     = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, payout registers and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            item_id_r       <= '0;
            change_amount_r <= 4'd0;
            vend_pulse_r    <= 1'b0;
            change_valid_r  <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (load_item_en_s) begin
                item_id_r <= item_sel;
            end else begin
                item_id_r <= item_id_r;
            end
            if (load_amount_en_s) begin
                change_amount_r <= load_amount_s;
            end else begin
                change_amount_r <= change_amount_r;
            end
            vend_pulse_r   <= (state_nxt_s == ST_VEND);
            change_valid_r <= (state_nxt_s == ST_CHANGE) || (state_nxt_s == ST_REFUND);
            busy_r         <= (state_nxt_s == ST_VEND) || (state_nxt_s == ST_CHANGE) ||
                              (state_nxt_s == ST_REFUND);
        end
    end

    // Same-cycle strobes are forced low while reset is held.
    assign add_en        = add_en_s & ~reset;
    assign add_value     = add_en ? coin_val_s : 4'd0;
    assign coin_reject   = coin_reject_s & ~reset;
    assign insuff_funds  = insuff_s & ~reset;
    assign clear_en      = clear_s & ~reset;
    assign vend_pulse    = vend_pulse_r;
    assign item_id       = item_id_r;
    assign change_valid  = change_valid_r;
    assign change_amount = change_amount_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_vend_ctrl.sv
module tb_vend_ctrl;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_valid, sel_valid, cancel, change_ack;
    logic [1:0] coin_code, item_sel;
    logic [3:0] balance;
    logic       add_en, clear_en, vend_pulse, change_valid, coin_reject, insuff_funds, busy;
    logic [3:0] add_value, change_amount;
    logic [1:0] item_id;

    int tests = 0;
    int fails = 0;

    // Reference model: phase 0 idle, 1 collecting, 2 dispensing, 3 paying out
    int ph, idle_n, pay_amt, vend_item;
    int prices[4]     = '{3, 5, 7, 10};
    int coin_units[4] = '{1, 2, 5, 10};

    always #5 clk = ~clk;

    vend_ctrl #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .reset(reset),
        .coin_valid(coin_valid), .coin_code(coin_code),
        .sel_valid(sel_valid), .item_sel(item_sel), .cancel(cancel),
        .balance(balance), .change_ack(change_ack),
        .add_en(add_en), .add_value(add_value), .clear_en(clear_en),
        .vend_pulse(vend_pulse), .item_id(item_id),
        .change_valid(change_valid), .change_amount(change_amount),
        .coin_reject(coin_reject), .insuff_funds(insuff_funds), .busy(busy)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " add_en"}, int'(add_en), 0);
        chk({tag, " add_value"}, int'(add_value), 0);
        chk({tag, " clear_en"}, int'(clear_en), 0);
        chk({tag, " vend_pulse"}, int'(vend_pulse), 0);
        chk({tag, " item_id"}, int'(item_id), 0);
        chk({tag, " change_valid"}, int'(change_valid), 0);
        chk({tag, " change_amount"}, int'(change_amount), 0);
        chk({tag, " coin_reject"}, int'(coin_reject), 0);
        chk({tag, " insuff_funds"}, int'(insuff_funds), 0);
        chk({tag, " busy"}, int'(busy), 0);
    endtask

    task automatic model_reset();
        ph = 0; idle_n = 0; pay_amt = 0; vend_item = 0;
    endtask

    // One clock cycle: drive inputs, predict, check at negedge, advance after posedge.
    task automatic step(input logic cv, input logic [1:0] cc, input logic sv,
                        input logic [1:0] is, input logic ca, input logic ak);
        int e_add, e_rej, e_ins, e_clr, nph, n_idle, n_amt, n_item, val, bal;
        logic got_add, got_clr;
        logic [3:0] got_val;
        coin_valid = cv; coin_code = cc; sel_valid = sv; item_sel = is;
        cancel = ca; change_ack = ak;
        val = coin_units[cc];
        bal = int'(balance);
        e_add = 0; e_rej = 0; e_ins = 0; e_clr = 0;
        nph = ph; n_idle = idle_n; n_amt = pay_amt; n_item = vend_item;
        if (ph <= 1) begin
            if (ca && ph == 1) begin
                nph = 3; n_amt = bal; e_rej = int'(cv);
            end else if (sv) begin
                n_idle = 0; e_rej = int'(cv);
                if (bal >= prices[is]) begin
                    nph = 2; n_amt = bal - prices[is]; n_item = int'(is);
                end else begin
                    e_ins = 1;
                end
            end else if (cv && (bal + val <= 15)) begin
                e_add = 1; nph = 1; n_idle = 0;
            end else begin
                e_rej = int'(cv);
                if (ph == 1 && idle_n == T - 1) begin
                    nph = 3; n_amt = bal;
                end else if (ph == 1) begin
                    n_idle = idle_n + 1;
                end
            end
        end else if (ph == 2) begin
            e_rej = int'(cv);
            if (pay_amt == 0) begin
                e_clr = 1; nph = 0;
            end else begin
                nph = 3;
            end
        end else begin
            e_rej = int'(cv);
            if (ak) begin
                e_clr = 1; nph = 0;
            end
        end
        @(negedge clk);
        chk("add_en", int'(add_en), e_add);
        if (e_add == 1) chk("add_value", int'(add_value), val);
        chk("coin_reject", int'(coin_reject), e_rej);
        chk("insuff_funds", int'(insuff_funds), e_ins);
        chk("clear_en", int'(clear_en), e_clr);
        chk("vend_pulse", int'(vend_pulse), (ph == 2) ? 1 : 0);
        if (ph == 2) chk("item_id", int'(item_id), vend_item);
        chk("change_valid", int'(change_valid), (ph == 3) ? 1 : 0);
        if (ph == 3) chk("change_amount", int'(change_amount), pay_amt);
        chk("busy", int'(busy), (ph >= 2) ? 1 : 0);
        got_add = add_en; got_clr = clear_en; got_val = add_value;
        @(posedge clk);
        #1;
        // External balance register follows the DUT's controls.
        if (got_clr) balance = 4'd0;
        else if (got_add) balance = balance + got_val;
        ph = nph; idle_n = n_idle; pay_amt = n_amt; vend_item = n_item;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        coin_valid = 1'b0; coin_code = 2'd0; sel_valid = 1'b0; item_sel = 2'd0;
        cancel = 1'b0; change_ack = 1'b0; balance = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        idle_steps(1);

        // Coins 5, 2, select item 0 -> change 4, coin during CHANGE rejected
        step(1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
        step(1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("bal_after_5_2", int'(balance), 7);
        step(1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        step(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        idle_steps(1);
        step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("bal_after_change", int'(balance), 0);
        idle_steps(1);

        // Exact payment, no change phase
        step(1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("bal_after_exact", int'(balance), 0);
        idle_steps(1);

        // Overflow reject at 15, then item 1 -> change 10
        step(1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0);
        step(1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
        step(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("bal_overflow_hold", int'(balance), 15);
        step(1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0);
        idle_steps(2);
        chk("change_amount_10", int'(change_amount), 10);
        step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);

        // Insufficient funds, then cancel refund
        step(1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0);
        step(1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0);
        chk("bal_after_insuff", int'(balance), 2);
        step(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0);
        step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);

        // Cancel + select + coin together with balance 5
        step(1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
        step(1'b1, 2'd0, 1'b1, 2'd1, 1'b1, 1'b0);
        step(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);

        // Timeout refund of one unit
        step(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        idle_steps(T);
        chk("timeout_change_valid", int'(change_valid), 1);
        chk("timeout_amount", int'(change_amount), 1);
        step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0);
        end
        // Drain to idle
        for (int i = 0; i < T + 4; i++) step(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1);

        // Reset asserted during CHANGE
        step(1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0);
        idle_steps(2);
        chk("pre_reset_change_valid", int'(change_valid), 1);
        coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0; change_ack = 1'b0;
        reset = 1'b1;
        #1;
        chk_all_zero("midreset");
        balance = 4'd0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_steps(2);
        step(1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("bal_after_reset_coin", int'(balance), 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
Main vending-machine sequencer. It takes coin, selection and cancel events and drives the add/clear controls of the 4-bit balance register. It checks price against the live balance, issues the vend, then hands back change or a refund through a valid/ack handshake. It sits between the front-panel/coin-acceptor logic and the balance register plus dispenser.

Parameters:
PRICE0, 4'd3, price of item 0
PRICE1, 4'd5, price of item 1
PRICE2, 4'd7, price of item 2
PRICE3, 4'd10, price of item 3
TIMEOUT_CYC, 1000, idle cycles in COLLECT before automatic refund (>=2)

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-high reset
coin_valid  input  1  one-cycle coin strobe
coin_code  input  2  00=1, 01=2, 10=5, 11=10 units
sel_valid  input  1  one-cycle item-select strobe
item_sel  input  2  selected item index
cancel  input  1  one-cycle cancel strobe
balance  input  4  current value from balance register
change_ack  input  1  dispenser has taken change_amount
add_en  output  1  to balance register: add add_value
add_value  output  4  decoded coin value
clear_en  output  1  to balance register: clear balance
vend_pulse  output  1  one-cycle dispense command
item_id  output  2  item being vended, valid with vend_pulse
change_valid  output  1  change_amount is valid, held until ack
change_amount  output  4  change or refund amount
coin_reject  output  1  one-cycle: coin returned, not credited
insuff_funds  output  1  one-cycle: selection refused
busy  output  1  high in VEND, CHANGE, REFUND

Behaviour:
- Reset value of every output and all registers is 0; state is IDLE. Reset asserted mid-transaction aborts immediately with no refund and no clear_en. The balance register is cleared by its own reset.
- States: IDLE, COLLECT, VEND, CHANGE, REFUND.
- Event priority in IDLE/COLLECT, one event per cycle: cancel > sel_valid > coin_valid. A coin dropped for priority raises coin_reject. A selection dropped for priority raises nothing.
- Coin acceptance is combinational (Mealy): add_en=1 and add_value=decoded value in the same cycle. The balance updates at the next edge. IDLE -> COLLECT on the next edge.
- Overflow: if balance+value > 15, add_en=0 and coin_reject=1. State is unchanged.
- Coins arriving in VEND/CHANGE/REFUND: coin_reject=1. sel_valid and cancel are ignored in those states.
- Selection: compare balance >= PRICE[item_sel] (unsigned, 4-bit).
  - Pass -> VEND. Register item_id and change_amount = balance - price.
  - Fail -> insuff_funds pulse; state unchanged. This applies in IDLE too (balance 0), unless the price is 0.
- VEND lasts exactly 1 cycle: vend_pulse=1, then go to CHANGE. If change_amount is 0, go straight to IDLE and pulse clear_en in the VEND cycle.
- CHANGE/REFUND: change_valid=1 and change_amount held stable until change_ack is sampled high. In that cycle clear_en=1; change_valid drops and state goes to IDLE at the next edge. An ack sampled with change_valid=0 is ignored.
- Cancel in COLLECT -> REFUND with change_amount=balance. Cancel in IDLE is ignored.
- Timeout: an idle counter runs only in COLLECT and resets on any accepted coin or any selection.
  - When the count reaches TIMEOUT_CYC-1 with no event: enter REFUND as for cancel.
  - An event in that same cycle takes priority and restarts the count.
- busy = (state in VEND, CHANGE, REFUND), registered from state.

Decomposition:
- Package vend_pkg holds:
  - state enum;
  - coin-code localparams;
  - a coin_value function (2-bit code -> 4-bit value);
  - the item-index width.
- Sub-module vend_idle_timer: counter with clear, enable and TIMEOUT_CYC parameter, and a one-cycle expired output. It is instantiated once.

Test Plan:
- Coins 5,2 then sel item0 (price 3) -> vend_pulse, item_id=0; change_valid with change_amount=4 until ack; clear_en in the ack cycle; balance then 0 and state IDLE.
- Coin 10 then sel item3 (price 10) -> vend_pulse; no change_valid; clear_en in the VEND cycle; back to IDLE.
- Coins 10,5 (balance 15) then coin 1 -> coin_reject=1, add_en=0, balance stays 15. Then sel item1 -> change_amount=10.
- Coin 2, sel item2 -> insuff_funds pulse, balance 2, still COLLECT. Then cancel -> REFUND with change_amount=2; ack -> clear_en, IDLE.
- Same cycle cancel+sel+coin with balance 5 -> REFUND with amount 5, coin_reject=1, no vend. Coin during CHANGE -> coin_reject.
- Coin 1, wait TIMEOUT_CYC cycles -> REFUND with amount 1. Separately, reset asserted during CHANGE -> all outputs 0 immediately, state IDLE.
